rx_event_buffer: RTL and testbench
==================================

RX_EVENT_BUFFER -- requirements
Module: rx_event_buffer

Interface
REQ-001 Parameter DEPTH, default 8: number of event entries; SHALL be a power of two, 2..64.
REQ-002 Parameter HOLDOFF, default 128: enabled cycles after an accepted trigger during which further triggers are ignored; SHALL be 1..65535.
REQ-003 crx_clk  in  1  single clock; all state on rising edge.
REQ-004 rrx_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 erx_en  in  1  enable; low freezes push, pop and holdoff.
REQ-006 isample_peak  in  16 signed  peak value from peak identification.
REQ-007 ireceived_seq  in  4  identified sequence index 0..15.
REQ-008 itime  in  16  timestamp of the peak.
REQ-009 itrigger  in  1  peak-detected strobe, may be held high for several cycles.
REQ-010 iready  in  1  ARM-side read acknowledge.
REQ-011 iclear  in  1  synchronous clear of overflow status.
REQ-012 ovalid  out  1  head entry present.
REQ-013 osample_peak / oreceived_seq / otime  out  16/4/16  head entry fields.
REQ-014 ocount  out  log2(DEPTH)+1  entries stored.
REQ-015 ooverflow  out  1  sticky: at least one event dropped.
REQ-016 odrop_count  out  8  events dropped, saturating.

Function
REQ-017 Register trig_prev samples itrigger every cycle regardless of erx_en; an event SHALL be detected only when itrigger=1, trig_prev=0, erx_en=1 and holdoff counter=0.
REQ-018 Each detected event SHALL load the holdoff counter with HOLDOFF-1, whether stored or dropped.
REQ-019 The holdoff counter SHALL decrement by 1 per cycle with erx_en=1 while nonzero; it SHALL hold when erx_en=0.
REQ-020 Detected event with ocount<DEPTH SHALL write {isample_peak, ireceived_seq, itime}, sampled that cycle, at the write pointer and advance it.
REQ-021 Detected event with ocount=DEPTH and no pop that cycle SHALL be dropped: ooverflow set, odrop_count incremented, saturating at 255.
REQ-022 Detected event with ocount=DEPTH and a pop that same cycle SHALL be stored; ocount unchanged.
REQ-023 Pop occurs when ovalid=1, iready=1 and erx_en=1; the read pointer advances. iready with ovalid=0 SHALL be ignored.
REQ-024 Simultaneous push and pop SHALL leave ocount unchanged; both pointers advance.
REQ-025 Pointers SHALL wrap modulo DEPTH.
REQ-026 Latency: event detected in cycle N SHALL produce ovalid=1 with that entry (when buffer was empty) from cycle N+1.
REQ-027 Head outputs SHALL be first-word-fall-through, showing the oldest entry, and SHALL read 0 when ovalid=0.
REQ-028 ovalid SHALL equal (ocount != 0).
REQ-029 iclear=1 SHALL zero ooverflow and odrop_count next cycle; a drop in the same cycle wins: ooverflow=1, odrop_count=1.
REQ-030 iclear SHALL act regardless of erx_en.

Reset
REQ-031 rrx_rst_n=0 SHALL immediately zero pointers, ocount, holdoff counter, trig_prev, ooverflow and odrop_count; outputs all 0.
REQ-032 Storage array SHALL NOT be reset; the REQ-027 masking hides it.
REQ-033 Reset asserted mid-operation SHALL discard all entries; the first edge after release is a valid event.

Structure
REQ-034 Shared package rx_pkg SHALL hold RX_EVT_DEPTH, RX_EVT_HOLDOFF, field widths (16/4/16) and the 36-bit event record layout {peak, seq, time}.
REQ-035 Storage SHALL be one sub-module rx_event_fifo_mem: DEPTH x 36 register array, single write port, asynchronous read, not reset.

Verification
REQ-036 Single event: itrigger 1-cycle pulse, peak=-1200, seq=5, time=0x1234 -> next cycle ovalid=1, fields match, ocount=1; pop -> ovalid=0, outputs 0.
REQ-037 Holdoff: itrigger high 10 cycles, then pulses at +50 and +200 cycles, HOLDOFF=128 -> exactly 2 entries stored.
REQ-038 Overflow: 10 spaced events, no pops, DEPTH=8 -> ocount=8, ooverflow=1, odrop_count=2; entries read in order 1..8; iclear -> flag and counter 0.
REQ-039 Full with simultaneous push+pop: ocount=8, event and iready same cycle -> ocount stays 8, no drop, new entry last out.
REQ-040 Enable/reset: erx_en=0 during trigger edge -> no entry; rrx_rst_n pulse with 3 entries stored -> ocount=0, ovalid=0 asynchronously.
REQ-041 Saturation: 300 drops -> odrop_count=255.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared constants and the event record layout for the RX event buffer.
package rx_pkg;
    localparam int RX_EVT_DEPTH   = 8;
    localparam int RX_EVT_HOLDOFF = 128;
    localparam int RX_PEAK_W      = 16;
    localparam int RX_SEQ_W       = 4;
    localparam int RX_TIME_W      = 16;
    localparam int RX_EVT_W       = RX_PEAK_W + RX_SEQ_W + RX_TIME_W;

    // One stored event, packed as {peak, seq, time} = 36 bits.
    typedef struct packed {
        logic signed [RX_PEAK_W-1:0] peak;
        logic [RX_SEQ_W-1:0]         seq;
        logic [RX_TIME_W-1:0]        ts;
    } rx_event_t;
endpackage

// File: rtl/rx_event_fifo_mem.sv
// Event storage: DEPTH x 36 register array, one write port, asynchronous read.
module rx_event_fifo_mem
    import rx_pkg::*;
#(
    parameter int DEPTH = RX_EVT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            crx_clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  rx_event_t       wdata,
    input  logic [AW-1:0]   raddr,
    output rx_event_t       rdata
);
    rx_event_t mem [DEPTH];

    // NOTE: storage has no reset; stale contents are masked by the valid logic upstream.
    always_ff @(posedge crx_clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/rx_event_buffer.sv
// Captures edge-detected peak events into a small FWFT buffer with trigger
// holdoff, overflow flagging and a saturating drop counter.
module rx_event_buffer
    import rx_pkg::*;
#(
    parameter int DEPTH   = RX_EVT_DEPTH,
    parameter int HOLDOFF = RX_EVT_HOLDOFF
) (
    input  logic                        crx_clk,
    input  logic                        rrx_rst_n,
    input  logic                        erx_en,
    input  logic signed [RX_PEAK_W-1:0] isample_peak,
    input  logic [RX_SEQ_W-1:0]         ireceived_seq,
    input  logic [RX_TIME_W-1:0]        itime,
    input  logic                        itrigger,
    input  logic                        iready,
    input  logic                        iclear,
    output logic                        ovalid,
    output logic signed [RX_PEAK_W-1:0] osample_peak,
    output logic [RX_SEQ_W-1:0]         oreceived_seq,
    output logic [RX_TIME_W-1:0]        otime,
    output logic [$clog2(DEPTH):0]      ocount,
    output logic                        ooverflow,
    output logic [7:0]                  odrop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [15:0]   HOLD_LOAD = 16'(HOLDOFF - 1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [15:0]   holdoff_cnt;
    logic          trig_prev;
    logic          detect;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;
    rx_event_t     wr_evt;
    rx_event_t     head;

    assign full   = (ocount == FULL_CNT);
    assign detect = itrigger && !trig_prev && erx_en && (holdoff_cnt == 16'd0);
    assign pop    = ovalid && iready && erx_en;
    // A pop in the same cycle frees the slot, so a full buffer can still accept.
    assign push   = detect && (!full || pop);
    assign drop   = detect && full && !pop;

    assign wr_evt = '{peak: isample_peak, seq: ireceived_seq, ts: itime};

    rx_event_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .crx_clk (crx_clk),
        .we      (push),
        .waddr   (wr_ptr),
        .wdata   (wr_evt),
        .raddr   (rd_ptr),
        .rdata   (head)
    );

    // Edge detector runs every cycle so a trigger held across an enable change is not re-seen.
    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n)
            trig_prev <= 1'b0;
        else
            trig_prev <= itrigger;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n) begin
            holdoff_cnt <= '0;
        end else if (erx_en) begin
            if (detect)
                holdoff_cnt <= HOLD_LOAD;
            else if (holdoff_cnt != 16'd0)
                holdoff_cnt <= holdoff_cnt - 16'd1;
        end
    end

    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ocount <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   ocount <= ocount + CW'(1);
                2'b01:   ocount <= ocount - CW'(1);
                default: ocount <= ocount;
            endcase
        end
    end

    // A drop coinciding with a clear restarts the statistics at one.
    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n) begin
            ooverflow   <= 1'b0;
            odrop_count <= '0;
        end else if (drop) begin
            ooverflow <= 1'b1;
            if (iclear)
                odrop_count <= 8'd1;
            else if (odrop_count != 8'hFF)
                odrop_count <= odrop_count + 8'd1;
        end else if (iclear) begin
            ooverflow   <= 1'b0;
            odrop_count <= '0;
        end
    end

    assign ovalid        = (ocount != '0);
    assign osample_peak  = ovalid ? head.peak : '0;
    assign oreceived_seq = ovalid ? head.seq  : '0;
    assign otime         = ovalid ? head.ts   : '0;
endmodule

// File: tb/tb_rx_event_buffer.sv
// Directed self-checking bench for rx_event_buffer (DEPTH=8, HOLDOFF=128).
module tb_rx_event_buffer;
    logic               crx_clk;
    logic               rrx_rst_n;
    logic               erx_en;
    logic signed [15:0] isample_peak;
    logic [3:0]         ireceived_seq;
    logic [15:0]        itime;
    logic               itrigger;
    logic               iready;
    logic               iclear;
    logic               ovalid;
    logic signed [15:0] osample_peak;
    logic [3:0]         oreceived_seq;
    logic [15:0]        otime;
    logic [3:0]         ocount;
    logic               ooverflow;
    logic [7:0]         odrop_count;

    int checks   = 0;
    int failures = 0;

    rx_event_buffer #(.DEPTH(8), .HOLDOFF(128)) dut (
        .crx_clk       (crx_clk),
        .rrx_rst_n     (rrx_rst_n),
        .erx_en        (erx_en),
        .isample_peak  (isample_peak),
        .ireceived_seq (ireceived_seq),
        .itime         (itime),
        .itrigger      (itrigger),
        .iready        (iready),
        .iclear        (iclear),
        .ovalid        (ovalid),
        .osample_peak  (osample_peak),
        .oreceived_seq (oreceived_seq),
        .otime         (otime),
        .ocount        (ocount),
        .ooverflow     (ooverflow),
        .odrop_count   (odrop_count)
    );

    initial crx_clk = 1'b0;
    always #5 crx_clk = ~crx_clk;

    task automatic step(input int n);
        repeat (n) @(posedge crx_clk);
        #1;
    endtask

    task automatic fire(input logic signed [15:0] p, input logic [3:0] s, input logic [15:0] t);
        isample_peak  = p;
        ireceived_seq = s;
        itime         = t;
        itrigger      = 1'b1;
        step(1);
        itrigger      = 1'b0;
    endtask

    task automatic pop_one();
        iready = 1'b1;
        step(1);
        iready = 1'b0;
    endtask

    // Head check of one expected entry: valid plus all three fields.
    task automatic expect_head(input string name, input logic signed [15:0] p,
                               input logic [3:0] s, input logic [15:0] t);
        checks++;
        if (ovalid !== 1'b1 || osample_peak !== p || oreceived_seq !== s || otime !== t) begin
            failures++;
            $display("FAIL %s: got v=%0b peak=%0d seq=%0d time=%h, want v=1 peak=%0d seq=%0d time=%h",
                     name, ovalid, osample_peak, oreceived_seq, otime, p, s, t);
        end
    endtask

    task automatic expect_status(input string name, input logic [3:0] cnt,
                                 input logic ovf, input logic [7:0] drops);
        checks++;
        if (ocount !== cnt || ooverflow !== ovf || odrop_count !== drops ||
            ovalid !== (cnt != 4'd0)) begin
            failures++;
            $display("FAIL %s: got count=%0d valid=%0b ovf=%0b drops=%0d, want count=%0d ovf=%0b drops=%0d",
                     name, ocount, ovalid, ooverflow, odrop_count, cnt, ovf, drops);
        end
    endtask

    task automatic expect_empty_head(input string name);
        checks++;
        if (ovalid !== 1'b0 || osample_peak !== 16'sd0 || oreceived_seq !== 4'd0 || otime !== 16'd0) begin
            failures++;
            $display("FAIL %s: got v=%0b peak=%0d seq=%0d time=%h, want all zero",
                     name, ovalid, osample_peak, oreceived_seq, otime);
        end
    endtask

    task automatic test_reset();
        rrx_rst_n = 1'b0;
        #2;
        expect_status("reset_status", 4'd0, 1'b0, 8'd0);
        expect_empty_head("reset_head");
        #1 rrx_rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_single();
        fire(-16'sd1200, 4'd5, 16'h1234);
        expect_head("single_head", -16'sd1200, 4'd5, 16'h1234);
        expect_status("single_count", 4'd1, 1'b0, 8'd0);
        pop_one();
        expect_empty_head("single_after_pop");
        expect_status("single_empty", 4'd0, 1'b0, 8'd0);
        step(128);
    endtask

    task automatic test_holdoff();
        isample_peak = 16'sd100; ireceived_seq = 4'd1; itime = 16'h0001;
        itrigger = 1'b1;
        step(10);
        itrigger = 1'b0;
        step(40);
        fire(16'sd300, 4'd3, 16'h0003);
        step(148);
        fire(16'sd200, 4'd2, 16'h0002);
        expect_status("holdoff_count", 4'd2, 1'b0, 8'd0);
        expect_head("holdoff_first", 16'sd100, 4'd1, 16'h0001);
        pop_one();
        expect_head("holdoff_second", 16'sd200, 4'd2, 16'h0002);
        pop_one();
        expect_status("holdoff_drained", 4'd0, 1'b0, 8'd0);
        step(128);
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 10; i++) begin
            fire(16'(i * 100), 4'(i), 16'(i));
            step(128);
        end
        expect_status("overflow_status", 4'd8, 1'b1, 8'd2);
        for (int i = 1; i <= 8; i++) begin
            expect_head($sformatf("overflow_order_%0d", i), 16'(i * 100), 4'(i), 16'(i));
            pop_one();
        end
        expect_status("overflow_drained", 4'd0, 1'b1, 8'd2);
        iclear = 1'b1;
        step(1);
        iclear = 1'b0;
        expect_status("overflow_cleared", 4'd0, 1'b0, 8'd0);
    endtask

    task automatic test_full_push_pop();
        for (int k = 1; k <= 8; k++) begin
            fire(16'(1000 + k), 4'(k), 16'(16'h0100 + k));
            step(128);
        end
        expect_status("full_before", 4'd8, 1'b0, 8'd0);
        iready = 1'b1;
        fire(-16'sd7, 4'd15, 16'hBEEF);
        iready = 1'b0;
        expect_status("full_push_pop", 4'd8, 1'b0, 8'd0);
        for (int k = 2; k <= 8; k++) begin
            expect_head($sformatf("full_order_%0d", k), 16'(1000 + k), 4'(k), 16'(16'h0100 + k));
            pop_one();
        end
        expect_head("full_new_last", -16'sd7, 4'd15, 16'hBEEF);
        pop_one();
        expect_status("full_drained", 4'd0, 1'b0, 8'd0);
        step(128);
    endtask

    task automatic test_enable_reset();
        erx_en = 1'b0;
        fire(16'sd55, 4'd7, 16'h0055);
        erx_en = 1'b1;
        step(2);
        expect_status("enable_no_entry", 4'd0, 1'b0, 8'd0);
        for (int k = 1; k <= 3; k++) begin
            fire(16'(-k), 4'(k), 16'(k));
            step(128);
        end
        expect_status("enable_three", 4'd3, 1'b0, 8'd0);
        erx_en = 1'b0;
        pop_one();
        erx_en = 1'b1;
        expect_status("enable_pop_frozen", 4'd3, 1'b0, 8'd0);
        fire(16'sd9, 4'd9, 16'h0009);
        #3 rrx_rst_n = 1'b0;
        #1;
        expect_status("reset_async", 4'd0, 1'b0, 8'd0);
        expect_empty_head("reset_async_head");
        #2 rrx_rst_n = 1'b1;
        step(1);
        fire(16'sd42, 4'd4, 16'h0042);
        expect_head("reset_first_edge", 16'sd42, 4'd4, 16'h0042);
        expect_status("reset_first_count", 4'd1, 1'b0, 8'd0);
        pop_one();
        step(128);
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 8; k++) begin
            fire(16'(k), 4'(k), 16'(k));
            step(128);
        end
        for (int k = 0; k < 300; k++) begin
            fire(16'sd1, 4'd1, 16'd1);
            step(128);
        end
        expect_status("sat_255", 4'd8, 1'b1, 8'd255);
        iclear = 1'b1;
        fire(16'sd2, 4'd2, 16'd2);
        iclear = 1'b0;
        expect_status("clear_vs_drop", 4'd8, 1'b1, 8'd1);
        iclear = 1'b1;
        step(1);
        iclear = 1'b0;
        expect_status("clear_after", 4'd8, 1'b0, 8'd0);
        expect_head("sat_head_kept", 16'sd0, 4'd0, 16'd0);
    endtask

    initial begin
        rrx_rst_n = 1'b0; erx_en = 1'b1; itrigger = 1'b0; iready = 1'b0; iclear = 1'b0;
        isample_peak = '0; ireceived_seq = '0; itime = '0;
        test_reset();
        test_single();
        test_holdoff();
        test_overflow();
        test_full_push_pop();
        test_enable_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
